// File: rtl/envelope_sequencer.sv
// Note-event sequencer for one envelope generator: buffers one pending event,
// loads the ADSR settings, pulses note_on, times the gate, pulses note_off and waits for done.
module envelope_sequencer #(
  parameter int LW = 18,
  parameter int TW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          ev_valid,
  output logic          ev_ready,
  input  logic [LW-1:0] ev_a,
  input  logic [LW-1:0] ev_b,
  input  logic [LW-1:0] ev_c,
  input  logic [LW-1:0] ev_d,
  input  logic [TW-1:0] ev_x,
  input  logic [TW-1:0] ev_y,
  input  logic [TW-1:0] ev_z,
  input  logic [TW-1:0] ev_gate,
  input  logic          abort,
  output logic [LW-1:0] eg_a,
  output logic [LW-1:0] eg_b,
  output logic [LW-1:0] eg_c,
  output logic [LW-1:0] eg_d,
  output logic [TW-1:0] eg_x,
  output logic [TW-1:0] eg_y,
  output logic [TW-1:0] eg_z,
  output logic          note_on,
  output logic          note_off,
  input  logic          eg_done,
  output logic          busy,
  output logic [CW-1:0] played_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_HOLD  = 3'd2,
    S_OFF   = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t        state_q;
  logic          pend_valid_q;
  logic [LW-1:0] pend_a_q, pend_b_q, pend_c_q, pend_d_q;
  logic [TW-1:0] pend_x_q, pend_y_q, pend_z_q, pend_gate_q;
  logic [LW-1:0] eg_a_q, eg_b_q, eg_c_q, eg_d_q;
  logic [TW-1:0] eg_x_q, eg_y_q, eg_z_q;
  logic [TW-1:0] gate_len_q;
  logic [TW-1:0] gate_cnt_q;
  logic [CW-1:0] played_q;

  logic accept;
  logic load;

  // abort suppresses both the capture of a new event and the start of a pending one
  assign accept = ev_valid && !pend_valid_q && !abort;
  assign load   = (state_q == S_IDLE) && pend_valid_q && !abort;

  // Pending event payload; only meaningful while pend_valid_q is set
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_a_q    <= ev_a;
      pend_b_q    <= ev_b;
      pend_c_q    <= ev_c;
      pend_d_q    <= ev_d;
      pend_x_q    <= ev_x;
      pend_y_q    <= ev_y;
      pend_z_q    <= ev_z;
      pend_gate_q <= ev_gate;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q      <= S_IDLE;
      pend_valid_q <= 1'b0;
      eg_a_q       <= '0;
      eg_b_q       <= '0;
      eg_c_q       <= '0;
      eg_d_q       <= '0;
      eg_x_q       <= '0;
      eg_y_q       <= '0;
      eg_z_q       <= '0;
      gate_len_q   <= '0;
      gate_cnt_q   <= '0;
      played_q     <= '0;
    end else begin
      if (abort) begin
        pend_valid_q <= 1'b0;
      end else if (accept) begin
        pend_valid_q <= 1'b1;
      end else if (load) begin
        pend_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (load) begin
            eg_a_q     <= pend_a_q;
            eg_b_q     <= pend_b_q;
            eg_c_q     <= pend_c_q;
            eg_d_q     <= pend_d_q;
            eg_x_q     <= pend_x_q;
            eg_y_q     <= pend_y_q;
            eg_z_q     <= pend_z_q;
            gate_len_q <= pend_gate_q;
            state_q    <= S_START;
          end
        end
        S_START: begin
          gate_cnt_q <= '0;
          state_q    <= abort ? S_OFF : S_HOLD;
        end
        S_HOLD: begin
          // equality stop before incrementing, so a full-scale gate_len never wraps
          if (abort || (gate_cnt_q == gate_len_q)) begin
            state_q <= S_OFF;
          end else begin
            gate_cnt_q <= gate_cnt_q + TW'(1);
          end
        end
        S_OFF: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (eg_done) begin
            played_q <= played_q + CW'(1);
            state_q  <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ev_ready   = !pend_valid_q;
  assign note_on    = (state_q == S_START);
  assign note_off   = (state_q == S_OFF);
  assign busy       = (state_q != S_IDLE) || pend_valid_q;
  assign played_cnt = played_q;
  assign eg_a       = eg_a_q;
  assign eg_b       = eg_b_q;
  assign eg_c       = eg_c_q;
  assign eg_d       = eg_d_q;
  assign eg_x       = eg_x_q;
  assign eg_y       = eg_y_q;
  assign eg_z       = eg_z_q;

endmodule

// File: tb/tb_envelope_sequencer.sv
// Bench for envelope_sequencer: a small generator model answers note_off with eg_done
// after eg_z cycles; expected notes are queued on acceptance and checked at note_on.
module tb_envelope_sequencer;
  localparam int LW = 18;
  localparam int TW = 32;
  localparam int CW = 16;
  localparam int EGW = 4 * LW + 3 * TW;

  typedef struct packed {
    logic [LW-1:0] a, b, c, d;
    logic [TW-1:0] x, y, z, gate;
  } note_t;

  logic          clk = 1'b0;
  logic          rst_b, ev_valid, ev_ready, abort, eg_done;
  logic [LW-1:0] ev_a, ev_b, ev_c, ev_d, eg_a, eg_b, eg_c, eg_d;
  logic [TW-1:0] ev_x, ev_y, ev_z, ev_gate, eg_x, eg_y, eg_z;
  logic          note_on, note_off, busy;
  logic [CW-1:0] played_cnt;
  logic [EGW-1:0] eg_vec;

  envelope_sequencer #(.LW(LW), .TW(TW), .CW(CW)) dut (
    .clk(clk), .rst_b(rst_b), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_a(ev_a), .ev_b(ev_b), .ev_c(ev_c), .ev_d(ev_d),
    .ev_x(ev_x), .ev_y(ev_y), .ev_z(ev_z), .ev_gate(ev_gate), .abort(abort),
    .eg_a(eg_a), .eg_b(eg_b), .eg_c(eg_c), .eg_d(eg_d),
    .eg_x(eg_x), .eg_y(eg_y), .eg_z(eg_z),
    .note_on(note_on), .note_off(note_off), .eg_done(eg_done),
    .busy(busy), .played_cnt(played_cnt)
  );

  always #5 clk = ~clk;
  assign eg_vec = {eg_a, eg_b, eg_c, eg_d, eg_x, eg_y, eg_z};

  note_t          exp_q[$];
  int             tests_run = 0;
  int             fails = 0;
  int             cyc = 0;
  int             done_cyc = -1;
  int             gen_cnt = 0;
  int             exp_played = 0;
  int             eg_glitch = 0;
  bit             armed = 0;
  bit             force_done = 0;
  logic [EGW-1:0] prev_eg;

  function automatic note_t mk(int a, int b, int c, int d, int x, int y, int z, int g);
    note_t n;
    n.a = LW'(a); n.b = LW'(b); n.c = LW'(c); n.d = LW'(d);
    n.x = TW'(x); n.y = TW'(y); n.z = TW'(z); n.gate = TW'(g);
    return n;
  endfunction

  function automatic logic [EGW-1:0] vec_of(note_t n);
    return {n.a, n.b, n.c, n.d, n.x, n.y, n.z};
  endfunction

  // One clock; samples 1 time unit after the edge and updates the generator model
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rst_b && !note_on && (eg_vec !== prev_eg)) eg_glitch++;
    prev_eg = eg_vec;
    eg_done = 1'b0;
    if (!rst_b) armed = 0;
    else if (note_off === 1'b1) begin
      gen_cnt = (eg_z == '0) ? 1 : int'(eg_z);
      armed = 1;
    end else if (armed) begin
      gen_cnt--;
      if (gen_cnt == 0) begin
        eg_done = 1'b1;
        armed = 0;
        done_cyc = cyc;
        exp_played++;
      end
    end
    eg_done = eg_done | force_done;
  endtask

  task automatic wait_on(output int c, output bit to);
    to = 1; c = -1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (note_on === 1'b1) begin c = cyc; to = 0; break; end
    end
  endtask

  task automatic wait_off(output int c, output bit to);
    to = 1; c = -1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (note_off === 1'b1) begin c = cyc; to = 0; break; end
    end
  endtask

  task automatic wait_idle(output bit to);
    to = 1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (busy === 1'b0) begin to = 0; break; end
    end
  endtask

  task automatic offer(input note_t n, output bit ok);
    ev_a = n.a; ev_b = n.b; ev_c = n.c; ev_d = n.d;
    ev_x = n.x; ev_y = n.y; ev_z = n.z; ev_gate = n.gate;
    ev_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (ev_ready === 1'b1 && !abort) begin
        exp_q.push_back(n);
        step();
        ok = 1;
        break;
      end
      step();
    end
    ev_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    step();
    step();
    tests_run++;
    if ({note_on, note_off, busy, ev_ready} !== 4'b0001) begin
      fails++; $display("FAIL reset_ctrl on/off/busy/ready=%b want 0001", {note_on, note_off, busy, ev_ready});
    end
    tests_run++;
    if (played_cnt !== '0) begin
      fails++; $display("FAIL reset_played got %0d want 0", played_cnt);
    end
    tests_run++;
    if (eg_vec !== '0) begin
      fails++; $display("FAIL reset_eg got %h want 0", eg_vec);
    end
    rst_b = 1'b1;
    prev_eg = eg_vec;
    force_done = 1;
    step();
    force_done = 0;
    step();
    tests_run++;
    if (played_cnt !== '0) begin
      fails++; $display("FAIL done_in_idle played got %0d want 0", played_cnt);
    end
  endtask

  task automatic test_single();
    note_t n, e;
    bit ok, to;
    int on_c, off_c;
    n = mk(0, 1000, 500, 0, 10, 10, 8, 20);
    offer(n, ok);
    wait_on(on_c, to);
    tests_run++;
    if (!ok || to || exp_q.size() == 0) begin
      fails++; $display("FAIL single_start ok=%0d timeout=%0d want ok=1 timeout=0", ok, to);
    end else begin
      e = exp_q.pop_front();
      tests_run++;
      if (eg_vec !== vec_of(e)) begin
        fails++; $display("FAIL single_eg got %h want %h", eg_vec, vec_of(e));
      end
      step();
      tests_run++;
      if (note_on !== 1'b0) begin
        fails++; $display("FAIL single_on_width note_on got %b want 0", note_on);
      end
      wait_off(off_c, to);
      tests_run++;
      if (to || (off_c - on_c) != int'(e.gate) + 2) begin
        fails++; $display("FAIL single_gate on->off got %0d want %0d", off_c - on_c, int'(e.gate) + 2);
      end
      tests_run++;
      if (busy !== 1'b1) begin
        fails++; $display("FAIL single_busy got %b want 1", busy);
      end
      wait_idle(to);
      tests_run++;
      if (to || played_cnt !== CW'(1) || CW'(exp_played) !== CW'(1)) begin
        fails++; $display("FAIL single_played got %0d want 1 (timeout=%0d)", played_cnt, to);
      end
      tests_run++;
      if (eg_vec !== vec_of(e) || eg_glitch != 0) begin
        fails++; $display("FAIL single_eg_stable got %h glitches=%0d want %h glitches=0", eg_vec, eg_glitch, vec_of(e));
      end
    end
  endtask

  task automatic test_gate0();
    note_t n, e;
    bit ok, to;
    int on_c, off_c, base;
    base = exp_played;
    n = mk(7, 2000, 100, 3, 50, 5, 4, 0);
    offer(n, ok);
    wait_on(on_c, to);
    tests_run++;
    if (!ok || to || exp_q.size() == 0) begin
      fails++; $display("FAIL gate0_start ok=%0d timeout=%0d want ok=1 timeout=0", ok, to);
    end else begin
      e = exp_q.pop_front();
      wait_off(off_c, to);
      tests_run++;
      if (to || (off_c - on_c) != 2) begin
        fails++; $display("FAIL gate0_off on->off got %0d want 2", off_c - on_c);
      end
      wait_idle(to);
      tests_run++;
      if (to || played_cnt !== CW'(base + 1)) begin
        fails++; $display("FAIL gate0_played got %0d want %0d", played_cnt, base + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    note_t na, nb, nc, e;
    bit ok, to;
    int on_c, early, base;
    base = exp_played;
    na = mk(1, 11, 21, 31, 3, 3, 5, 20);
    nb = mk(2, 12, 22, 32, 4, 4, 6, 6);
    nc = mk(3, 13, 23, 33, 5, 5, 7, 2);
    offer(na, ok);
    wait_on(on_c, to);
    e = exp_q.pop_front();
    tests_run++;
    if (to || eg_vec !== vec_of(e)) begin
      fails++; $display("FAIL b2b_a_eg got %h want %h", eg_vec, vec_of(e));
    end
    repeat (3) step();
    offer(nb, ok);
    tests_run++;
    if (!ok || ev_ready !== 1'b0) begin
      fails++; $display("FAIL b2b_b_accept ok=%0d ev_ready=%b want ok=1 ev_ready=0", ok, ev_ready);
    end
    // C is held on the inputs while B waits in the slot
    ev_a = nc.a; ev_b = nc.b; ev_c = nc.c; ev_d = nc.d;
    ev_x = nc.x; ev_y = nc.y; ev_z = nc.z; ev_gate = nc.gate;
    ev_valid = 1'b1;
    early = 0;
    to = 1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (note_on === 1'b1) begin to = 0; break; end
      if (ev_ready !== 1'b0) early++;
    end
    tests_run++;
    if (to || (cyc - done_cyc) != 2) begin
      fails++; $display("FAIL b2b_b_start done->on got %0d want 2 (timeout=%0d)", cyc - done_cyc, to);
    end
    tests_run++;
    if (early != 0 || ev_ready !== 1'b1) begin
      fails++; $display("FAIL full_slot_ready early=%0d ready_at_start=%b want 0 and 1", early, ev_ready);
    end
    e = exp_q.pop_front();
    tests_run++;
    if (eg_vec !== vec_of(e)) begin
      fails++; $display("FAIL b2b_b_eg got %h want %h", eg_vec, vec_of(e));
    end
    exp_q.push_back(nc);
    step();
    ev_valid = 1'b0;
    tests_run++;
    if (ev_ready !== 1'b0) begin
      fails++; $display("FAIL full_slot_c_accept ev_ready got %b want 0", ev_ready);
    end
    wait_on(on_c, to);
    e = exp_q.pop_front();
    tests_run++;
    if (to || (on_c - done_cyc) != 2 || eg_vec !== vec_of(e)) begin
      fails++; $display("FAIL full_slot_c_start done->on=%0d eg=%h want 2 and %h", on_c - done_cyc, eg_vec, vec_of(e));
    end
    wait_idle(to);
    tests_run++;
    if (to || played_cnt !== CW'(base + 3) || exp_played != base + 3) begin
      fails++; $display("FAIL b2b_played got %0d want %0d", played_cnt, base + 3);
    end
    tests_run++;
    if (eg_glitch != 0) begin
      fails++; $display("FAIL b2b_eg_stable glitches got %0d want 0", eg_glitch);
    end
  endtask

  task automatic test_abort();
    note_t na, nb, e;
    bit ok, to;
    int on_c, ons, base;
    base = exp_played;
    na = mk(5, 15, 25, 35, 6, 6, 6, 100);
    nb = mk(9, 19, 29, 39, 2, 2, 2, 3);
    offer(na, ok);
    wait_on(on_c, to);
    e = exp_q.pop_front();
    repeat (5) step();
    offer(nb, ok);
    tests_run++;
    if (!ok || ev_ready !== 1'b0) begin
      fails++; $display("FAIL abort_b_pending ok=%0d ev_ready=%b want 1 and 0", ok, ev_ready);
    end
    e = exp_q.pop_back();
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests_run++;
    if (note_off !== 1'b1 || ev_ready !== 1'b1) begin
      fails++; $display("FAIL abort_effect note_off=%b ev_ready=%b want 1 and 1", note_off, ev_ready);
    end
    wait_idle(to);
    tests_run++;
    if (to || played_cnt !== CW'(base + 1)) begin
      fails++; $display("FAIL abort_played got %0d want %0d", played_cnt, base + 1);
    end
    ons = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (note_on === 1'b1) ons++;
    end
    tests_run++;
    if (ons != 0) begin
      fails++; $display("FAIL abort_flushed note_on count got %0d want 0", ons);
    end
    // abort and an incoming event on the same edge: the event is dropped
    ev_valid = 1'b1;
    abort = 1'b1;
    step();
    ev_valid = 1'b0;
    abort = 1'b0;
    step();
    tests_run++;
    if (ev_ready !== 1'b1 || busy !== 1'b0 || note_on !== 1'b0) begin
      fails++; $display("FAIL abort_vs_accept ready=%b busy=%b on=%b want 1 0 0", ev_ready, busy, note_on);
    end
  endtask

  task automatic test_reset_mid_wait();
    note_t n, e;
    bit ok, to;
    int on_c, off_c, ons;
    n = mk(4, 14, 24, 34, 8, 8, 50, 3);
    offer(n, ok);
    wait_on(on_c, to);
    e = exp_q.pop_front();
    wait_off(off_c, to);
    repeat (4) step();
    rst_b = 1'b0;
    step();
    tests_run++;
    if ({note_on, note_off, busy, ev_ready} !== 4'b0001 || played_cnt !== '0 || eg_vec !== '0) begin
      fails++; $display("FAIL reset_mid_wait on/off/busy/ready=%b played=%0d eg=%h want 0001 0 0",
                        {note_on, note_off, busy, ev_ready}, played_cnt, eg_vec);
    end
    rst_b = 1'b1;
    armed = 0;
    exp_played = 0;
    prev_eg = eg_vec;
    ons = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (note_on === 1'b1) ons++;
    end
    tests_run++;
    if (ons != 0 || played_cnt !== '0 || busy !== 1'b0) begin
      fails++; $display("FAIL after_reset_idle ons=%0d played=%0d busy=%b want 0 0 0", ons, played_cnt, busy);
    end
  endtask

  initial begin
    rst_b = 1'b0; ev_valid = 1'b0; abort = 1'b0; eg_done = 1'b0;
    ev_a = '0; ev_b = '0; ev_c = '0; ev_d = '0;
    ev_x = '0; ev_y = '0; ev_z = '0; ev_gate = '0;
    prev_eg = '0;
    test_reset();
    test_single();
    test_gate0();
    test_back_to_back();
    test_abort();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/envelope_sequencer.md
Name: envelope_sequencer

Overview:
- Note-event initiator that drives one envelope_generator instance.
- Accepts note events over a valid/ready handshake and buffers one pending event.
- For each event it loads the ADSR levels and durations, pulses note_on, holds the gate for a programmed number of cycles, pulses note_off, then waits for the generator's done before starting the next note.
- Sits between the note/event source (control logic or CPU-side FIFO) and the envelope generator.

Parameters:
- LW, 18, level width (a..d).
- TW, 32, duration width (x, y, z, gate).
- CW, 16, played-note counter width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_b  in  1  reset; synchronous, active-low.
- ev_valid  in  1  event offered.
- ev_ready  out  1  event can be accepted.
- ev_a, ev_b, ev_c, ev_d  in  LW each  event levels: start, peak, sustain, end.
- ev_x, ev_y, ev_z  in  TW each  event attack, decay and release durations.
- ev_gate  in  TW  cycles from note_on to note_off, minus 2.
- abort  in  1  cut the current note short and flush the pending event.
- eg_a, eg_b, eg_c, eg_d  out  LW each  registered levels to the generator.
- eg_x, eg_y, eg_z  out  TW each  registered durations to the generator.
- note_on  out  1  one-cycle start pulse.
- note_off  out  1  one-cycle release pulse.
- eg_done  in  1  generator release complete (combinational from the generator).
- busy  out  1  high when state != IDLE or an event is pending.
- played_cnt  out  CW  number of completed notes; wraps.

Behaviour:
- Reset (rst_b low at posedge): state=IDLE, pending empty, all eg_* = 0, gate counter = 0, played_cnt = 0. note_on, note_off and busy are 0.
- Reset is honoured in any state. It may arrive mid-note; the generator shares the same reset.
- Pending buffer: ev_ready = !pend_valid (combinational from a register only).
  - On a posedge with ev_valid & ev_ready, capture ev_* into pending and set pend_valid.
  - Inputs are ignored while ev_ready=0.
- FSM states: IDLE, START, HOLD, OFF, WAIT. note_on and note_off are Moore decodes of the registered state.
- IDLE: if pend_valid, at the next edge copy pending to eg_* and gate_len, clear pend_valid, go to START.
  - The pending slot is freed on that same edge, so a new event can be accepted one cycle later.
- START: note_on=1 for exactly one cycle. Gate counter is cleared to 0. Next state is HOLD.
- HOLD: gate counter increments each cycle.
  - When counter == gate_len, go to OFF at the next edge.
  - HOLD lasts gate_len+1 cycles, so note_off is high exactly gate_len+2 cycles after the note_on cycle.
  - gate_len=0 still produces a 1-cycle HOLD.
- OFF: note_off=1 for exactly one cycle. Next state is WAIT.
- WAIT: stay until eg_done=1. On that edge go to IDLE and increment played_cnt (wraps at 2^CW).
- Once loaded, eg_* only change on the IDLE->START edge, so they are stable for the whole note.
- A new event may be accepted in any state while the slot is empty.
- abort (sampled at posedge):
  - In START or HOLD: next state is OFF and pend_valid is cleared.
  - In OFF or WAIT: only pend_valid is cleared.
  - In IDLE: pend_valid is cleared, so a pending event is not started.
  - If abort and ev_valid&ev_ready fall on the same edge, abort wins and the incoming event is dropped.
- eg_done outside WAIT is ignored.
- played_cnt counts only notes that reach the WAIT->IDLE edge. Aborted notes still count once done arrives.
- Counter width: gate counter is TW bits. Comparison is equality only; gate_len = 2^TW-1 must terminate without wrap.

Test Plan:
- Single note: ev_a=0, ev_b=1000, ev_c=500, ev_d=0, ev_x=10, ev_y=10, ev_z=8, ev_gate=20, with a real envelope_generator attached.
  - note_on high 1 cycle; note_off high exactly 22 cycles after note_on.
  - busy stays high until eg_done; played_cnt goes 0->1; eg_* hold their values throughout.
- gate=0 corner: ev_gate=0 → note_off 2 cycles after note_on.
  - Generator enters RELEASE from ATTACK with riv = its out_value at that moment; done follows, played_cnt increments.
- Back-to-back: offer event A, then event B while A is in HOLD.
  - B is accepted, ev_ready drops; B is not started until A's eg_done.
  - B's note_on occurs 2 cycles after A's done cycle; played_cnt ends at 2.
- Full slot: with the slot full, hold ev_valid=1 with a third event C.
  - C is not accepted until the cycle after B moves to START; C then completes third.
- Abort: assert abort for 1 cycle mid-HOLD (gate=100) with B pending.
  - note_off the next cycle, pend_valid cleared, B never played, played_cnt=1 after done.
- Reset mid-WAIT: drop rst_b for 1 cycle.
  - All outputs 0 and state IDLE after the edge; played_cnt=0; ev_ready=1.
